rr_stream_mux: RTL and testbench
================================

// Module: rr_stream_mux
// PURPOSE
//   Parametrised N-channel to 1 stream multiplexer with a registered output.
//   Each input has a valid/ready handshake. Arbitration is either fixed (external select) or round-robin.
//   Sits between multiple producer units and one shared consumer (bus, register-file write port, ALU input).
//   Output is registered: 1-cycle latency, full throughput under backpressure.
// PARAMETERS
//   WIDTH   4   data bits per channel
//   N_CH    4   number of input channels, >= 2
//   RR_MODE 1   1 = round-robin arbitration; 0 = channel chosen by sel input
//   CH_W    $clog2(N_CH)   derived (localparam): channel index width
// PORTS
//   clk        in   1            clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   in_data    in   N_CH*WIDTH   packed channel data; channel i = in_data[i*WIDTH +: WIDTH]
//   in_valid   in   N_CH         channel i offers a word
//   in_ready   out  N_CH         channel i word accepted this cycle (combinational)
//   sel        in   CH_W         selected channel; used only when RR_MODE=0
//   out_data   out  WIDTH        registered output word
//   out_ch     out  CH_W         index of the channel out_data came from
//   out_valid  out  1            out_data/out_ch hold a word
//   out_ready  in   1            consumer accepts the word this cycle
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Reset takes effect immediately, mid-transfer included.
//     The pending word is dropped. in_ready=0 while rst_n=0.
//   load = ~out_valid | out_ready. The output register accepts a new word only when load=1.
//   Grant (combinational, one-hot or zero):
//     RR_MODE=1: first i with in_valid[i]=1, searching from rr_ptr upward and wrapping N_CH-1 -> 0.
//     RR_MODE=0: grant[sel]=in_valid[sel]. Other channels are never granted. An out-of-range sel (>= N_CH) grants nothing.
//   in_ready[i] = grant[i] & load. A transfer on channel i happens when in_valid[i] & in_ready[i].
//   On a clock edge with a transfer on channel k:
//     out_data <= channel k data; out_ch <= k; out_valid <= 1.
//     RR_MODE=1 only: rr_ptr <= (k==N_CH-1) ? 0 : k+1.
//   On a clock edge with load=1 and no grant: out_valid <= 0. out_data and out_ch hold their values.
//   With out_valid=1 and out_ready=0: out_data, out_ch, out_valid and rr_ptr all hold. in_ready is all zero.
//   If out_ready=1 and a new grant occur in the same cycle, the consumer takes the old word and the new word loads.
//     No bubble; 1 word per cycle sustained.
//   rr_ptr changes only on a transfer. An idle cycle or a stall does not move priority.
//   Fairness: with all channels continuously valid and out_ready=1, grants cycle 0,1,...,N_CH-1,0,...
//   Inputs are not buffered. A producer keeps in_data/in_valid stable until in_ready=1.
//   Latency: word visible on out_data the cycle after its transfer.
// TESTING  (WIDTH=4, N_CH=4)
//   1 Reset: drive rst_n=0 mid-transfer with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 with no clock edge;
//     after release, first grant goes to ch0.
//   2 RR fairness: all in_valid=1111, data ch_i=4'hA+i, out_ready=1 -> out_ch sequence 0,1,2,3,0.
//     out_data sequence A,B,C,D,A. out_valid stays 1.
//   3 Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0000, out_data/out_ch stable.
//     Next grant goes to the channel after the held out_ch.
//   4 Sparse/wrap: rr_ptr=3, only ch1 valid (data 4'h5) -> ch1 granted; out_ch=1, out_data=5, rr_ptr=2 after the edge.
//     Then only ch3 and ch0 valid -> ch3 granted first.
//   5 Fixed mode (RR_MODE=0): sel=2, in_valid=1111 -> only in_ready[2]=1; out_ch=2 each cycle.
//     sel=2 with in_valid[2]=0 -> out_valid drops to 0 after the current word drains.
//   6 Simultaneous drain+load: out_valid=1, out_ready=1, ch1 valid -> new word loaded in the same edge, no idle cycle.
//     Pulling in_valid low -> out_valid=0 one edge later.

Source files
------------

// File: rtl/rr_stream_mux.sv
// N-channel to 1 stream multiplexer with valid/ready handshakes and a registered output.
// Arbitration is round-robin (RR_MODE=1) or driven by an external channel select (RR_MODE=0).
module rr_stream_mux #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned N_CH    = 4,
    parameter int unsigned RR_MODE = 1,
    localparam int unsigned CH_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*WIDTH-1:0]  in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic [CH_W-1:0]        sel,
    output logic [WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    logic [CH_W-1:0]  rr_ptr;
    logic [N_CH-1:0]  grant;
    logic [CH_W-1:0]  scan_idx;
    logic             found;
    logic [CH_W-1:0]  win_ch;
    logic [WIDTH-1:0] win_data;
    logic             load;
    logic             xfer;

    // Grant: first valid channel at or after rr_ptr (wrapping), or the selected channel.
    always_comb begin
        grant    = '0;
        scan_idx = rr_ptr;
        found    = 1'b0;
        if (RR_MODE != 0) begin
            for (int unsigned o = 0; o < N_CH; o++) begin
                if (!found && in_valid[scan_idx]) begin
                    grant[scan_idx] = 1'b1;
                    found           = 1'b1;
                end
                scan_idx = (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;
            end
        end else if (32'(sel) < N_CH) begin
            grant[sel] = in_valid[sel];
        end
    end

    always_comb begin
        win_ch   = '0;
        win_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant[i]) begin
                win_ch   = CH_W'(i);
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign load     = ~out_valid | out_ready;
    assign xfer     = load & (|grant);
    // Nothing is accepted while reset is held, even though load is 1 then.
    assign in_ready = (rst_n && load) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_data  <= win_data;
            out_ch    <= win_ch;
            out_valid <= 1'b1;
            if (RR_MODE != 0) begin
                rr_ptr <= (win_ch == LAST_CH) ? '0 : win_ch + 1'b1;
            end
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: one round-robin and one fixed-select instance (WIDTH=4, N_CH=4).
module tb_rr_stream_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;

    logic [3:0]  rr_valid, rr_ready;
    logic [3:0]  rr_odata;
    logic [1:0]  rr_och;
    logic        rr_ovalid, rr_oready;

    logic [3:0]  fx_valid, fx_ready;
    logic [1:0]  fx_sel;
    logic [3:0]  fx_odata;
    logic [1:0]  fx_och;
    logic        fx_ovalid, fx_oready;

    int n_tests = 0;
    int n_fail  = 0;

    rr_stream_mux #(.WIDTH(4), .N_CH(4), .RR_MODE(1)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (rr_valid),
        .in_ready  (rr_ready),
        .sel       (2'd0),
        .out_data  (rr_odata),
        .out_ch    (rr_och),
        .out_valid (rr_ovalid),
        .out_ready (rr_oready)
    );

    rr_stream_mux #(.WIDTH(4), .N_CH(4), .RR_MODE(0)) u_fx (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (fx_valid),
        .in_ready  (fx_ready),
        .sel       (fx_sel),
        .out_data  (fx_odata),
        .out_ch    (fx_och),
        .out_valid (fx_ovalid),
        .out_ready (fx_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rr_out(input string tag, input logic v, input logic [1:0] ch,
                              input logic [3:0] d);
        chk({tag, ".valid"}, 32'(rr_ovalid), 32'(v));
        chk({tag, ".ch"},    32'(rr_och),    32'(ch));
        chk({tag, ".data"},  32'(rr_odata),  32'(d));
    endtask

    initial begin
        logic [1:0] exp_ch;
        in_data   = 16'hDCBA;
        rst_n     = 1'b0;
        rr_valid  = 4'hF;
        rr_oready = 1'b1;
        fx_valid  = 4'h0;
        fx_sel    = 2'd2;
        fx_oready = 1'b1;

        // Reset state, no ready while reset held
        #2;
        chk_rr_out("reset", 1'b0, 2'd0, 4'h0);
        chk("reset.in_ready", 32'(rr_ready), 32'h0);
        chk("reset.fx_valid", 32'(fx_ovalid), 32'h0);
        edge_sample();
        chk("reset.held_valid", 32'(rr_ovalid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel.in_ready", 32'(rr_ready), 32'b0001);

        // Round-robin fairness: 0,1,2,3,0
        edge_sample();
        chk_rr_out("rr0", 1'b1, 2'd0, 4'hA);
        for (int j = 1; j <= 4; j++) begin
            exp_ch = 2'(j % 4);
            edge_sample();
            chk_rr_out($sformatf("rr%0d", j), 1'b1, exp_ch, 4'hA + 4'(exp_ch));
        end

        // Backpressure: hold ch0/A three cycles, nothing accepted
        rr_oready = 1'b0;
        #1;
        chk("bp.in_ready", 32'(rr_ready), 32'h0);
        for (int j = 0; j < 3; j++) begin
            edge_sample();
            chk_rr_out($sformatf("bp%0d", j), 1'b1, 2'd0, 4'hA);
            chk($sformatf("bp%0d.in_ready", j), 32'(rr_ready), 32'h0);
        end
        rr_oready = 1'b1;
        #1;
        chk("bp.release_ready", 32'(rr_ready), 32'b0010);
        edge_sample();
        chk_rr_out("bp.next", 1'b1, 2'd1, 4'hB);

        // Sparse/wrap: get rr_ptr to 3, then only ch1 valid with data 5
        edge_sample();
        chk_rr_out("sp.ch2", 1'b1, 2'd2, 4'hC);
        rr_valid = 4'b0010;
        in_data  = 16'hDC5A;
        #1;
        chk("sp.in_ready1", 32'(rr_ready), 32'b0010);
        edge_sample();
        chk_rr_out("sp.ch1", 1'b1, 2'd1, 4'h5);
        rr_valid = 4'b1001;
        #1;
        chk("sp.in_ready3", 32'(rr_ready), 32'b1000);
        edge_sample();
        chk_rr_out("sp.ch3", 1'b1, 2'd3, 4'hD);

        // Simultaneous drain + load, then drain to idle
        rr_valid = 4'b0010;
        #1;
        chk("dl.in_ready", 32'(rr_ready), 32'b0010);
        edge_sample();
        chk_rr_out("dl.load", 1'b1, 2'd1, 4'h5);
        rr_valid = 4'b0000;
        #1;
        chk("dl.idle_ready", 32'(rr_ready), 32'h0);
        edge_sample();
        chk_rr_out("dl.drain", 1'b0, 2'd1, 4'h5);
        edge_sample();
        chk_rr_out("dl.idle2", 1'b0, 2'd1, 4'h5);
        // Idle cycles must not move priority (rr_ptr stays 2)
        rr_valid = 4'hF;
        #1;
        chk("dl.ptr_kept", 32'(rr_ready), 32'b0100);
        edge_sample();
        chk_rr_out("dl.ch2", 1'b1, 2'd2, 4'hC);

        // Asynchronous reset mid-transfer with a held word
        rr_oready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_rr_out("areset", 1'b0, 2'd0, 4'h0);
        chk("areset.in_ready", 32'(rr_ready), 32'h0);
        rst_n     = 1'b1;
        rr_oready = 1'b1;
        #1;
        chk("areset.ready_ch0", 32'(rr_ready), 32'b0001);
        edge_sample();
        chk_rr_out("areset.first", 1'b1, 2'd0, 4'hA);
        rr_valid = 4'h0;

        // Fixed-select instance: sel=2, all valid
        fx_valid = 4'hF;
        #1;
        chk("fx.in_ready", 32'(fx_ready), 32'b0100);
        for (int j = 0; j < 3; j++) begin
            edge_sample();
            chk($sformatf("fx%0d.ch", j),    32'(fx_och),    32'd2);
            chk($sformatf("fx%0d.data", j),  32'(fx_odata),  32'hC);
            chk($sformatf("fx%0d.valid", j), 32'(fx_ovalid), 32'd1);
        end
        fx_valid = 4'b1011;
        #1;
        chk("fx.off_ready", 32'(fx_ready), 32'h0);
        chk("fx.still_valid", 32'(fx_ovalid), 32'd1);
        edge_sample();
        chk("fx.drained", 32'(fx_ovalid), 32'd0);
        chk("fx.ch_hold", 32'(fx_och), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
